// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - state, error-code and magic encodings shared by the UART boot loader
package boot_pkg;

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  localparam logic [15:0] BOOT_MAGIC = 16'hB007;

endpackage

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - parses the UART word stream into memory writes and holds the CPU in reset until loaded
// Optional trailing payload checksum word: define CHECKSUM_EN.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          MAX_WORDS = 4096,
  parameter logic [15:0] MAGIC     = BOOT_MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [1:0]        err_code
);

`ifdef CHECKSUM_EN
  localparam logic [2:0] ST_TAIL = ST_CSUM;
  logic [31:0] acc;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

  logic [2:0]        state, state_nx;
  logic [1:0]        err_nx;
  logic [16:0]       n_words, idx, hdr_len;
  logic [ADDR_W-1:0] base;
  logic              is_magic, len_ok, hdr_event, hdr_accept;

  assign is_magic   = (word_in[31:16] == MAGIC);
  assign hdr_len    = {1'b0, word_in[15:0]};
  assign len_ok     = (hdr_len <= 17'(MAX_WORDS));
  // A magic word restarts parsing from DONE or ERR; anything else there is ignored.
  assign hdr_event  = word_valid &&
                      ((state == ST_HDR) || (((state == ST_DONE) || (state == ST_ERR)) && is_magic));
  assign hdr_accept = hdr_event && is_magic && len_ok;

  always_comb begin
    state_nx = state;
    err_nx   = err_code;
    if (hdr_event) begin
      if (!is_magic) begin
        state_nx = ST_ERR;
        err_nx   = ERR_MAGIC;
      end else if (!len_ok) begin
        state_nx = ST_ERR;
        err_nx   = ERR_LEN;
      end else begin
        state_nx = ST_ADDR;
        err_nx   = ERR_NONE;
      end
    end else if (word_valid) begin
      case (state)
        ST_ADDR: begin
          if (word_in[1:0] != 2'b00) begin
            state_nx = ST_ERR;
            err_nx   = ERR_LEN;
          end else if (n_words == 17'd0) begin
            state_nx = ST_TAIL;
          end else begin
            state_nx = ST_DATA;
          end
        end
        ST_DATA: if (idx + 17'd1 == n_words) state_nx = ST_TAIL;
`ifdef CHECKSUM_EN
        ST_CSUM: begin
          if (word_in == acc) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_ERR;
            err_nx   = ERR_CSUM;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // cpu_rst and load_done follow the next state so they stay registered yet change with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_HDR;
      err_code  <= ERR_NONE;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
    end else begin
      state     <= state_nx;
      err_code  <= err_nx;
      cpu_rst   <= (state_nx != ST_DONE);
      load_done <= (state_nx == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      n_words   <= '0;
      idx       <= '0;
      base      <= '0;
`ifdef CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (hdr_accept) begin
        n_words <= hdr_len;
`ifdef CHECKSUM_EN
        acc     <= '0;
`endif
      end else if (word_valid && (state == ST_ADDR)) begin
        base <= word_in[ADDR_W-1:0];
        idx  <= '0;
      end else if (word_valid && (state == ST_DATA)) begin
        mem_we    <= 1'b1;
        mem_addr  <= base + ADDR_W'({idx, 2'b00});
        mem_wdata <= word_in;
        idx       <= idx + 17'd1;
`ifdef CHECKSUM_EN
        acc       <= acc + word_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader (honours CHECKSUM_EN)
module tb_uart_boot_loader;

`ifdef CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic [1:0]  err_code;

  uart_boot_loader dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called at a negedge; returns at a negedge after the word has been sampled.
  task automatic put(input logic [31:0] w, input int gap);
    word_in = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] q[$], input bit b2b);
    foreach (q[i]) put(q[i], b2b ? 0 : int'($urandom_range(0, 2)));
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pay_sum(input logic [31:0] pay[$]);
    logic [31:0] s = '0;
    foreach (pay[i]) s += pay[i];
    return s;
  endfunction

  // Reference outcome of one load, taken straight from the header/address/checksum rules.
  function automatic logic [1:0] model_err(input logic [31:0] hdr, input logic [31:0] addr, input bit csum_bad);
    if (hdr[31:16] != 16'hB007) return 2'b01;
    if (hdr[15:0] > 16'd4096) return 2'b10;
    if (addr[1:0] != 2'b00) return 2'b10;
    if (CSUM_ON && csum_bad) return 2'b11;
    return 2'b00;
  endfunction

  function automatic void build(input logic [31:0] hdr, input logic [31:0] addr, input logic [31:0] csum,
                                input logic [31:0] pay[$], output logic [31:0] q[$]);
    q = {};
    q.push_back(hdr);
    if (hdr[31:16] != 16'hB007 || hdr[15:0] > 16'd4096) return;
    q.push_back(addr);
    if (addr[1:0] != 2'b00) return;
    foreach (pay[i]) q.push_back(pay[i]);
    if (CSUM_ON) q.push_back(csum);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL idle_cpu_rst: got %b expected 1", cpu_rst); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL idle_load_done: got %b expected 0", load_done); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL idle_err_code: got %b expected 00", err_code); end
    n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL idle_writes: got %0d expected 0", wr_addr.size()); end
  endtask

  task automatic test_spec_load();
    logic [31:0] q[$];
    q = {32'hB007_0002, 32'h0000_0100, 32'h0000_0013, 32'h0010_0093};
    if (CSUM_ON) q.push_back(32'h0010_00A6);
    clear_writes();
    send(q, 1'b1);
    n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL load_write_count: got %0d expected 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_checks++; if (wr_addr[0] !== 32'h100) begin n_fail++; $display("FAIL load_addr0: got %h expected 00000100", wr_addr[0]); end
      n_checks++; if (wr_data[0] !== 32'h13) begin n_fail++; $display("FAIL load_data0: got %h expected 00000013", wr_data[0]); end
      n_checks++; if (wr_addr[1] !== 32'h104) begin n_fail++; $display("FAIL load_addr1: got %h expected 00000104", wr_addr[1]); end
      n_checks++; if (wr_data[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL load_data1: got %h expected 00100093", wr_data[1]); end
    end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b expected 1", load_done); end
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL load_cpu_rst: got %b expected 0", cpu_rst); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL load_err_code: got %b expected 00", err_code); end
  endtask

  task automatic test_bad_magic();
    logic [31:0] q[$];
    pulse_reset();
    clear_writes();
    put(32'hDEAD_0001, 0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL magic_err_code: got %b expected 01", err_code); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL magic_cpu_rst: got %b expected 1", cpu_rst); end
    n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL magic_writes: got %0d expected 0", wr_addr.size()); end
    q = {32'hB007_0002, 32'h0000_0100, 32'h0000_0013, 32'h0010_0093};
    if (CSUM_ON) q.push_back(32'h0010_00A6);
    send(q, 1'b0);
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL magic_recover_err: got %b expected 00", err_code); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL magic_recover_done: got %b expected 1", load_done); end
    n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL magic_recover_writes: got %0d expected 2", wr_addr.size()); end
  endtask

  task automatic test_bad_len();
    clear_writes();
    put(32'hB007_0002, 0);
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reload_cpu_rst: got %b expected 1", cpu_rst); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reload_load_done: got %b expected 0", load_done); end
    put(32'h0000_0102, 0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL align_err_code: got %b expected 10", err_code); end
    n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL align_writes: got %0d expected 0", wr_addr.size()); end
    pulse_reset();
    put(32'hB007_1001, 0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL len_err_code: got %b expected 10", err_code); end
    put(32'hB007_0001, 0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b expected 00", err_code); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL err_clear_cpu_rst: got %b expected 1", cpu_rst); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL err_clear_done: got %b expected 0", load_done); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_csum_mismatch();
    logic [31:0] q[$];
    pulse_reset();
    clear_writes();
    q = {32'hB007_0002, 32'h0000_0100, 32'h0000_0013, 32'h0010_0093, 32'h0010_00A7};
    send(q, 1'b1);
    n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL csum_writes: got %0d expected 2", wr_addr.size()); end
    n_checks++; if (err_code !== 2'b11) begin n_fail++; $display("FAIL csum_err_code: got %b expected 11", err_code); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL csum_load_done: got %b expected 0", load_done); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL csum_cpu_rst: got %b expected 1", cpu_rst); end
  endtask
`endif

  task automatic test_reset_midload();
    clear_writes();
    put(32'hB007_0004, 0);
    put(32'h0000_0200, 0);
    put(32'hCAFE_0001, 0);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_we: got %b expected 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_wdata: got %h expected 0", mem_wdata); end
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_cpu_rst: got %b expected 1", cpu_rst); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", load_done); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL midrst_err: got %b expected 00", err_code); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    put(32'h1234_5678, 0);
    repeat (2) @(negedge clk);
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL midrst_hdr_state: got %b expected 01", err_code); end
    n_checks++; if (wr_addr.size() != 1) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 1", wr_addr.size()); end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int it = 0; it < 10; it++) begin
      logic [31:0] pay[$];
      logic [31:0] q[$];
      logic [31:0] hdr, base, csum;
      logic [1:0]  exp_err;
      int n, exp_n, bad, gaps, kind;
      bit csum_bad;
      n = int'($urandom_range(0, 8));
      kind = int'($urandom_range(0, 5));
      base = (it == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      if (kind == 1) base[1:0] = 2'($urandom_range(1, 3));
      pay = {};
      for (int i = 0; i < n; i++) pay.push_back($urandom());
      hdr = {16'hB007, 16'(n)};
      if (kind == 2) begin
        hdr[15:0] = 16'($urandom_range(4097, 65535));
        pay = {};
      end
      csum_bad = (kind == 3);
      csum = pay_sum(pay) + (csum_bad ? 32'd1 : 32'd0);
      exp_err = model_err(hdr, base, csum_bad);
      exp_n = (exp_err == 2'b00 || exp_err == 2'b11) ? pay.size() : 0;
      build(hdr, base, csum, pay, q);
      clear_writes();
      send(q, it[0]);
      n_checks++; if (wr_addr.size() != exp_n) begin n_fail++; $display("FAIL rand%0d_writes: got %0d expected %0d", it, wr_addr.size(), exp_n); end
      bad = 0;
      gaps = 0;
      for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
        if (wr_addr[i] !== base + 32'(4 * i) || wr_data[i] !== pay[i]) bad++;
        if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_contents: got %0d wrong writes expected 0", it, bad); end
      if (it[0]) begin
        n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL rand%0d_b2b: got %0d gaps expected 0", it, gaps); end
      end
      n_checks++; if (err_code !== exp_err) begin n_fail++; $display("FAIL rand%0d_err: got %b expected %b", it, err_code, exp_err); end
      n_checks++; if (load_done !== (exp_err == 2'b00)) begin n_fail++; $display("FAIL rand%0d_done: got %b expected %b", it, load_done, exp_err == 2'b00); end
      n_checks++; if (cpu_rst !== (exp_err != 2'b00)) begin n_fail++; $display("FAIL rand%0d_cpu_rst: got %b expected %b", it, cpu_rst, exp_err != 2'b00); end
    end
  endtask

  task automatic test_max_len();
    logic [31:0] pay[$];
    logic [31:0] q[$];
    logic [31:0] base;
    int bad, gaps;
    base = $urandom() & 32'hFFFF_FFFC;
    for (int i = 0; i < 4096; i++) pay.push_back($urandom());
    build(32'hB007_1000, base, pay_sum(pay), pay, q);
    clear_writes();
    send(q, 1'b1);
    n_checks++; if (wr_addr.size() != 4096) begin n_fail++; $display("FAIL max_writes: got %0d expected 4096", wr_addr.size()); end
    bad = 0;
    gaps = 0;
    for (int i = 0; i < 4096 && i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== base + 32'(4 * i) || wr_data[i] !== pay[i]) bad++;
      if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL max_contents: got %0d wrong writes expected 0", bad); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL max_b2b: got %0d gaps expected 0", gaps); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL max_done: got %b expected 1", load_done); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL max_err: got %b expected 00", err_code); end
  endtask

  initial begin
    test_reset();
    test_spec_load();
    test_bad_magic();
    test_bad_len();
`ifdef CHECKSUM_EN
    test_csum_mismatch();
`endif
    test_reset_midload();
    test_random();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
